// File: rtl/ntru_pkg.sv
// ntru_pkg: shared constants and types for the S3 trit packer.
// Provides coefficient/byte counts, derived widths, the packer state enum
// and a helper that maps a 2-bit coefficient code to its trit value.
package ntru_pkg;

  localparam int S3_COEFFS      = 700;
  localparam int PACK_BYTES     = 140;
  localparam int TRITS_PER_BYTE = 5;

  localparam int POLY_W  = 2 * S3_COEFFS;       // packed coefficient vector width
  localparam int CHUNK_W = 2 * TRITS_PER_BYTE;  // bits feeding one output byte

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PACK = 2'd2,
    ST_DONE = 2'd3
  } s3_state_t;

  // 2'b11 is not a legal code; it contributes nothing to the packed value.
  function automatic logic [7:0] trit_val(input logic [1:0] code);
    return (code == 2'b11) ? 8'd0 : {6'd0, code};
  endfunction

endpackage

// File: rtl/s3_pack5.sv
// s3_pack5: five ternary coefficients -> one base-3 byte (0..242).
// Latency: purely combinational. Backpressure: none (no state).
// Ports: i_trits [9:0] (coefficient i at bits [2i+1:2i]), o_byte [7:0].
module s3_pack5
  import ntru_pkg::*;
(
  input  logic [CHUNK_W-1:0] i_trits,
  output logic [7:0]         o_byte
);

  logic [7:0] w_acc;

  // Horner evaluation from the most significant trit; the largest
  // intermediate is 242, so 8 bits never wrap.
  always_comb begin
    w_acc = 8'd0;
    for (int i = TRITS_PER_BYTE - 1; i >= 0; i--) begin
      w_acc = (w_acc * 8'd3) + trit_val(i_trits[2*i +: 2]);
    end
  end

  assign o_byte = w_acc;

endmodule

// File: rtl/s3_pack.sv
// s3_pack: packs a 700-trit polynomial into 140 bytes, five trits per byte.
// Latency: byte 0 valid two cycles after start is sampled, then one byte per
// cycle. Backpressure: byte_out/byte_idx/byte_valid hold while !byte_ready.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   poly[1400:1]    coefficient k at poly[2k+2:2k+1]; captured on start
//   start           job request, honoured only in IDLE
//   busy            high in every state except IDLE
//   byte_out/_idx   packed byte and its index; byte_valid/byte_ready handshake
//   done            one-cycle pulse after the last byte is accepted
//   err             sticky invalid-coefficient flag
// Build option: define S3_PACK_CHECK_EN to enable 2'b11 detection on err;
// without it err is tied low.
module s3_pack
  import ntru_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [POLY_W:1] poly,
  input  logic            start,
  output logic            busy,
  output logic [7:0]      byte_out,
  output logic            byte_valid,
  input  logic            byte_ready,
  output logic [7:0]      byte_idx,
  output logic            done,
  output logic            err
);

  localparam logic [7:0] LAST_IDX = 8'(PACK_BYTES - 1);

  s3_state_t       r_state;
  s3_state_t       w_next;
  logic [POLY_W:1] r_poly;
  logic [7:0]      r_byte;
  logic [7:0]      r_idx;

  logic              w_hs;
  logic [7:0]        w_sel;
  logic [10:0]       w_base;
  logic [CHUNK_W-1:0] w_chunk;
  logic [7:0]        w_packed;

  assign w_hs = byte_valid & byte_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_LOAD;
      ST_LOAD: w_next = ST_PACK;
      ST_PACK: if (w_hs && (r_idx == LAST_IDX)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Byte selection: LOAD prepares byte 0, PACK prepares the byte after the
  // one on the output so it can be registered on the handshake edge. The
  // index is clamped on the last byte to keep the slice in range.
  always_comb begin
    w_sel = 8'd0;
    if (r_state == ST_PACK) begin
      w_sel = (r_idx == LAST_IDX) ? LAST_IDX : (r_idx + 8'd1);
    end
  end

  assign w_base  = (11'(w_sel) * 11'(CHUNK_W)) + 11'd1;
  assign w_chunk = r_poly[w_base +: CHUNK_W];

  s3_pack5 u_pack5 (
    .i_trits (w_chunk),
    .o_byte  (w_packed)
  );

  // Shadow register and output byte pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_poly <= '0;
      r_byte <= 8'd0;
      r_idx  <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_poly <= poly;
        end
        ST_LOAD: begin
          r_byte <= w_packed;
          r_idx  <= 8'd0;
        end
        ST_PACK: begin
          if (w_hs && (r_idx != LAST_IDX)) begin
            r_byte <= w_packed;
            r_idx  <= r_idx + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign byte_valid = (r_state == ST_PACK);
  assign done       = (r_state == ST_DONE);
  assign byte_out   = r_byte;
  assign byte_idx   = r_idx;

`ifdef S3_PACK_CHECK_EN
  logic w_bad;
  logic r_err;

  always_comb begin
    w_bad = 1'b0;
    for (int k = 0; k < S3_COEFFS; k++) begin
      w_bad = w_bad | (r_poly[2*k+2] & r_poly[2*k+1]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_IDLE) && start) begin
      r_err <= 1'b0;
    end else if ((r_state == ST_LOAD) && w_bad) begin
      r_err <= 1'b1;
    end
  end

  // The check result is visible during LOAD itself and latched from then on.
  assign err = r_err | ((r_state == ST_LOAD) & w_bad);
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_s3_pack.sv
module tb_s3_pack;
  import ntru_pkg::*;

`ifdef S3_PACK_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk;
  logic            rst;
  logic [1400:1]   poly;
  logic            start;
  logic            busy;
  logic [7:0]      byte_out;
  logic            byte_valid;
  logic            byte_ready;
  logic [7:0]      byte_idx;
  logic            done;
  logic            err;

  int n_chk;
  int n_err;

  logic [7:0] exp_b [140];
  logic [7:0] cap   [140];

  s3_pack dut (
    .clk        (clk),
    .rst        (rst),
    .poly       (poly),
    .start      (start),
    .busy       (busy),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_idx   (byte_idx),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: each byte is the base-3 number formed by five coefficients,
  // lowest coefficient least significant; code 3 counts as zero.
  function automatic void build_exp(input logic [1400:1] p);
    for (int j = 0; j < 140; j++) begin
      int s;
      int w;
      s = 0;
      w = 1;
      for (int i = 0; i < 5; i++) begin
        int k;
        int v;
        k = 5 * j + i;
        v = 2 * int'(p[2*k+2]) + int'(p[2*k+1]);
        if (v == 3) v = 0;
        s = s + v * w;
        w = w * 3;
      end
      exp_b[j] = 8'(s);
    end
  endfunction

  function automatic bit has3(input logic [1400:1] p);
    bit r;
    r = 1'b0;
    for (int k = 0; k < 700; k++) if (p[2*k+2] && p[2*k+1]) r = 1'b1;
    return r;
  endfunction

  function automatic logic [1400:1] rand_poly();
    logic [1400:1] r;
    for (int k = 0; k < 700; k++) begin
      logic [1:0] v;
      v = 2'($urandom_range(0, 2));
      r[2*k+1] = v[0];
      r[2*k+2] = v[1];
    end
    return r;
  endfunction

  // mode 0: ready always high; 1: ready low 3 cycles at byte 5;
  // 2: random ready; 3: start pulse with new poly at byte 10;
  // 4: reset pulse at byte 70 (job abandoned).
  task automatic run_job(input logic [1400:1] p, input int mode, input string tag);
    int         nhs;
    int         cyc;
    int         stall_left;
    bit         fin;
    bit         aborted;
    bit         pulsed;
    bit         r;
    bit         exp_err;
    logic       pv;
    logic       pr;
    logic [7:0] pb;
    logic [7:0] pi;

    build_exp(p);
    exp_err = CHK_EN && has3(p);

    poly       = p;
    start      = 1'b1;
    byte_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_load_busy"}, 32'(busy), 32'd1);
    chk({tag, "_load_vld"}, 32'(byte_valid), 32'd0);
    chk({tag, "_load_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    chk({tag, "_lat_vld"}, 32'(byte_valid), 32'd1);
    chk({tag, "_lat_idx"}, 32'(byte_idx), 32'd0);

    nhs = 0; cyc = 0; stall_left = -1;
    fin = 1'b0; aborted = 1'b0; pulsed = 1'b0;
    pv = 1'b0; pr = 1'b0; pb = '0; pi = '0;

    while (!fin && cyc < 3000) begin
      start = 1'b0;
      if (pv && !pr) begin
        chk({tag, "_hold_vld"}, 32'(byte_valid), 32'd1);
        chk({tag, "_hold_out"}, 32'(byte_out), 32'(pb));
        chk({tag, "_hold_idx"}, 32'(byte_idx), 32'(pi));
      end
      if (done) begin
        chk({tag, "_hs_total"}, 32'(nhs), 32'd140);
        fin = 1'b1;
      end else if (mode == 4 && byte_valid && byte_idx == 8'd70) begin
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rst_vld"}, 32'(byte_valid), 32'd0);
        chk({tag, "_rst_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rst_idx"}, 32'(byte_idx), 32'd0);
        chk({tag, "_rst_out"}, 32'(byte_out), 32'd0);
        chk({tag, "_rst_done"}, 32'(done), 32'd0);
        chk({tag, "_rst_err"}, 32'(err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) begin
          @(negedge clk);
          chk({tag, "_post_rst_busy"}, 32'(busy), 32'd0);
          chk({tag, "_post_rst_vld"}, 32'(byte_valid), 32'd0);
        end
        aborted = 1'b1;
        fin = 1'b1;
      end else begin
        r = 1'b1;
        case (mode)
          1: begin
            if (byte_valid && byte_idx == 8'd5 && stall_left < 0) stall_left = 3;
            if (stall_left > 0) begin
              r = 1'b0;
              stall_left--;
            end
          end
          2: r = ($urandom_range(0, 3) != 0);
          3: begin
            if (byte_valid && byte_idx == 8'd10 && !pulsed) begin
              start  = 1'b1;
              poly   = ~p;
              pulsed = 1'b1;
            end
          end
          default: ;
        endcase
        if (byte_valid && r) begin
          if (nhs < 140) begin
            chk({tag, "_byte"}, 32'(byte_out), 32'(exp_b[nhs]));
            chk({tag, "_idx"}, 32'(byte_idx), 32'(nhs));
            cap[nhs] = byte_out;
          end else begin
            chk({tag, "_extra_byte"}, 32'd1, 32'd0);
          end
          nhs++;
        end
        byte_ready = r;
        pv = byte_valid; pr = r; pb = byte_out; pi = byte_idx;
        @(negedge clk);
        cyc++;
      end
    end

    if (!fin) chk({tag, "_timeout"}, 32'd0, 32'd1);
    if (fin && !aborted) begin
      @(negedge clk);
      chk({tag, "_done_once"}, 32'(done), 32'd0);
      chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
      chk({tag, "_idle_vld"}, 32'(byte_valid), 32'd0);
      chk({tag, "_err_sticky"}, 32'(err), 32'(exp_err));
    end
  endtask

  initial begin
    logic [1400:1] p;
    n_chk      = 0;
    n_err      = 0;
    rst        = 1'b1;
    start      = 1'b0;
    byte_ready = 1'b0;
    poly       = '0;

    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_vld", 32'(byte_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_out", 32'(byte_out), 32'd0);
    chk("rst_idx", 32'(byte_idx), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    p = '0;
    run_job(p, 0, "zero");

    p = '0;
    for (int k = 0; k < 700; k++) p[2*k+2] = 1'b1;
    run_job(p, 0, "all2");
    chk("all2_b0", 32'(cap[0]), 32'hF2);
    chk("all2_b139", 32'(cap[139]), 32'hF2);

    p = '0;
    p[1]    = 1'b1;
    p[1399] = 1'b1;
    run_job(p, 0, "ends");
    chk("ends_b0", 32'(cap[0]), 32'h01);
    chk("ends_b70", 32'(cap[70]), 32'h00);
    chk("ends_b139", 32'(cap[139]), 32'h51);

    run_job(rand_poly(), 1, "stall");
    run_job(rand_poly(), 2, "rndrdy");
    run_job(rand_poly(), 4, "abort");
    run_job(rand_poly(), 0, "restart");

    p = '0;
    p[7] = 1'b1;
    p[8] = 1'b1;
    run_job(p, 3, "bad3");
    chk("bad3_b0", 32'(cap[0]), 32'h00);

    run_job(rand_poly(), 0, "clear");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/s3_pack.md
S3_PACK -- requirements
Module: s3_pack

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port poly, input, 1400 ([1400:1]), 700 ternary coefficients; coefficient k (0..699) at poly[2k+2:2k+1].
REQ-004 SHALL have port start, input, 1, request to pack poly; sampled only in IDLE.
REQ-005 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-006 SHALL have port byte_out, output, 8, current packed byte.
REQ-007 SHALL have port byte_valid, output, 1, byte_out holds a valid byte.
REQ-008 SHALL have port byte_ready, input, 1, consumer accepts byte_out when byte_valid && byte_ready at a rising edge.
REQ-009 SHALL have port byte_idx, output, 8, index (0..139) of the byte on byte_out.
REQ-010 SHALL have port done, output, 1, one-cycle pulse after byte 139 is accepted.
REQ-011 SHALL have port err, output, 1, sticky flag for invalid coefficient encoding (see Configuration).

Function
REQ-012 SHALL use the coefficient encoding 2'b00=0, 2'b01=1, 2'b10=2 (i.e. -1 mod 3); 2'b11 is invalid and packs as 0.
REQ-013 SHALL compute byte j (0..139) = c[5j] + 3*c[5j+1] + 9*c[5j+2] + 27*c[5j+3] + 81*c[5j+4]; result 0..242, fits in 8 bits unsigned, no wrap.
REQ-014 SHALL implement states IDLE, LOAD, PACK, DONE.
- IDLE -> LOAD on start.
- LOAD -> PACK after one cycle.
- PACK -> DONE on the handshake of byte 139.
- DONE -> IDLE after one cycle.
REQ-015 SHALL register poly into an internal shadow register at the rising edge where start is sampled in IDLE; later changes to poly SHALL NOT affect the current job.
REQ-016 SHALL assert byte_valid with byte 0 on the second rising edge after start is sampled (fixed latency 2 cycles).
REQ-017 SHALL hold byte_out, byte_idx and byte_valid stable while byte_valid && !byte_ready.
REQ-018 SHALL present the next byte in the cycle after a handshake, so one byte per cycle is sustained when byte_ready is held high.
REQ-019 SHALL deassert byte_valid in DONE and IDLE, and pulse done in DONE only.
REQ-020 SHALL ignore start whenever the state is not IDLE.
REQ-021 SHALL allow start to be sampled in the IDLE cycle that immediately follows DONE.

Reset
REQ-022 SHALL on rst, immediately and asynchronously, set state=IDLE, byte_out=0, byte_valid=0, byte_idx=0, done=0, busy=0, err=0, and clear the shadow register.
REQ-023 SHALL abandon a job on rst asserted mid-PACK, without emitting further bytes, and SHALL need a new start after rst is released.

Configuration
REQ-024 SHALL, with macro S3_PACK_CHECK_EN defined, set err when any loaded coefficient is 2'b11 (checked in LOAD); err stays set until rst or the next start.
REQ-025 SHALL, without S3_PACK_CHECK_EN, tie err to 0 and include no checking logic; 2'b11 still packs as 0.

Structure
REQ-026 SHALL take the constants S3_COEFFS=700, PACK_BYTES=140, TRITS_PER_BYTE=5 and the state enum from shared package ntru_pkg.
REQ-027 SHALL place the 5-trit-to-byte conversion in combinational sub-module s3_pack5 (10-bit in, 8-bit out), instantiated once.

Verification
REQ-028 SHALL check: all-zero poly, byte_ready=1 -> 140 bytes of 0x00, byte 0 two cycles after start, done pulses once.
REQ-029 SHALL check: all coefficients 2'b10 -> every byte 0xF2 (242).
REQ-030 SHALL check: only c0=1 and c699=1 -> byte 0=0x01, byte 139=0x51, all other bytes 0x00.
REQ-031 SHALL check: byte_ready low for 3 cycles at byte_idx 5 -> byte_out and byte_idx held, no byte lost or duplicated, 140 handshakes total.
REQ-032 SHALL check: rst pulsed at byte_idx 70 -> byte_valid and busy low with no clock edge; a new start restarts at byte 0.
REQ-033 SHALL check: with S3_PACK_CHECK_EN, c3=2'b11 -> err=1 from LOAD onward and byte 0=0x00; start mid-PACK is ignored.
